// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor and its bench.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  function automatic int seg_width(int width, int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SEG-bit ripple of full-adder cells; also exposes the carry into
// the segment MSB so the final stage can derive signed overflow.
module adder_slice #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic c;

  always_comb begin
    c    = cin;
    cmsb = cin;
    sum  = '0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/sub split into STAGES registered carry segments with valid/ready flow control.
// Optional ADDSUB_SATURATE_EN clamps overflowing results to signed max/min at the final stage.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be divisible by STAGES");
  end

  logic adv;

  // Register k sits after stage k-1; register STAGES drives the outputs.
  logic [STAGES:1]            vld_q, vld_d;
  logic [STAGES:1][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES:1]            c_q, c_d;
  logic                       ovf_q, ovf_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + ~cin, so invert once on entry and carry B' forward.
  assign b_in = (in_op == OP_SUB) ? ~in_b : in_b;
  assign c_in = (in_op == OP_SUB) ? ~in_cin : in_cin;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, s_src, nxt;
    logic             c_src;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout, seg_cmsb;

    if (s == 0) begin : g_head
      assign a_src = in_a;
      assign b_src = b_in;
      assign s_src = '0;
      assign c_src = c_in;
    end else begin : g_body
      assign a_src = a_q[s];
      assign b_src = b_q[s];
      assign s_src = s_q[s];
      assign c_src = c_q[s];
    end

    adder_slice #(.SEG(SEG)) u_slice (
      .a    (a_src[s*SEG +: SEG]),
      .b    (b_src[s*SEG +: SEG]),
      .cin  (c_src),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      nxt                = s_src;
      nxt[s*SEG +: SEG]  = seg_sum;
    end

    assign a_d[s+1] = a_src;
    assign b_d[s+1] = b_src;
    assign c_d[s+1] = seg_cout;

    if (s == STAGES - 1) begin : g_tail
      logic ovf;
      assign ovf   = seg_cmsb ^ seg_cout;
      assign ovf_d = ovf;
`ifdef ADDSUB_SATURATE_EN
      assign s_d[s+1] = !ovf ? nxt :
                        a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_d[s+1] = nxt;
`endif
    end else begin : g_mid
      assign s_d[s+1] = nxt;
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[1] = in_valid;
    for (int k = 2; k <= STAGES; k++) vld_d[k] = vld_q[k-1];
  end

  // Data regs only load for valid beats, so bubbles leave the last result on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      for (int k = 1; k <= STAGES; k++) begin
        if (vld_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (vld_d[STAGES]) ovf_q <= ovf_d;
    end
  end

  // Finished lower operand bits and the last stage's operand copy are never read.
  logic operand_unused;
  assign operand_unused = ^{a_q, b_q};

  assign out_valid = vld_q[STAGES];
  assign out_sum   = s_q[STAGES];
  assign out_cout  = c_q[STAGES];
  assign out_ovf   = ovf_q;

endmodule
